pc_sequencer: RTL and testbench

//  Program-counter sequencer of the single-cycle YouseiOS core; consumer of the ALU's Zero/Resultado outputs.

---
 rtl/yousei_pkg.sv | 31 +++
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_next_mux.sv | 56 +++++
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/yousei_pkg.sv
// yousei_pkg: definitions shared by the YouseiOS core blocks.
//   - opcode constants used by the PC sequencer
//   - seq_state_e: sequencer state (RUN, WAIT_IN, WAIT_OUT, HALTED)
//   - is_branch(): true for the conditional branch opcodes
package yousei_pkg;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_LOG   = 6'd1;
  localparam logic [5:0] OP_JUMP  = 6'd5;
  localparam logic [5:0] OP_IN    = 6'd8;
  localparam logic [5:0] OP_OUT   = 6'd9;
  localparam logic [5:0] OP_BEQ   = 6'd10;
  localparam logic [5:0] OP_BNE   = 6'd11;
  localparam logic [5:0] OP_JR    = 6'd19;
  localparam logic [5:0] OP_SWAPK = 6'd33;
  localparam logic [5:0] OP_HLT   = 6'd63;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_IN  = 2'd1,
    WAIT_OUT = 2'd2,
    HALTED   = 2'd3
  } seq_state_e;

  // BEQ and BNE share the same select rule: the ALU has already folded the
  // equal/not-equal sense into zero.
  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder/ALU/IO side of the PC sequencer.
//   Parameter ADDR_W: PC width.
//   Core -> sequencer: opcode, zero, alu_result, branch_tgt, jr_tgt,
//                      in_valid, out_ready
//   Sequencer -> core: pc, in_ack, out_valid, stall, halted
//   modport master: the core side (drives instruction fields and IO status)
//   modport slave : the sequencer
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);

  logic [5:0]        opcode;
  logic              zero;
  logic [ADDR_W-1:0] alu_result;
  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic              in_valid;
  logic              out_ready;

  logic [ADDR_W-1:0] pc;
  logic              in_ack;
  logic              out_valid;
  logic              stall;
  logic              halted;

  modport master (
    output opcode, zero, alu_result, branch_tgt, jr_tgt, in_valid, out_ready,
    input  pc, in_ack, out_valid, stall, halted
  );

  modport slave (
    input  opcode, zero, alu_result, branch_tgt, jr_tgt, in_valid, out_ready,
    output pc, in_ack, out_valid, stall, halted
  );

endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC select for an instruction that retires
// from RUN. Stalls and the IN/OUT handshakes are handled by the caller.
//   opcode, zero                 : current instruction and ALU Zero flag
//   pc                           : current PC
//   alu_result/branch_tgt/jr_tgt : JUMP, BEQ/BNE and JR targets
//   kret (KERNEL_SWAP_EN only)   : saved return address for the kernel swap
//   pc_inc                       : pc + 1, wrapping modulo 2^ADDR_W
//   next_pc                      : selected next PC
// Optional feature macro: KERNEL_SWAP_EN (SWAPK enters the kernel at
// KERNEL_BASE, JR with a zero target returns to kret).
module pc_next_mux
  import yousei_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
`ifdef KERNEL_SWAP_EN
  ,
  parameter logic [ADDR_W-1:0] KERNEL_BASE = '0
`endif
) (
  input  logic [5:0]        opcode,
  input  logic              zero,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] branch_tgt,
  input  logic [ADDR_W-1:0] jr_tgt,
`ifdef KERNEL_SWAP_EN
  input  logic [ADDR_W-1:0] kret,
`endif
  output logic [ADDR_W-1:0] pc_inc,
  output logic [ADDR_W-1:0] next_pc
);

  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned (which would infer a latch).
    next_pc = pc_inc;
    if (is_branch(opcode)) begin
      if (zero) next_pc = branch_tgt;
    end else begin
      case (opcode)
        OP_JUMP:  next_pc = alu_result;
`ifdef KERNEL_SWAP_EN
        OP_JR:    next_pc = (jr_tgt == '0) ? kret : jr_tgt;
        OP_SWAPK: next_pc = KERNEL_BASE;
`else
        OP_JR:    next_pc = jr_tgt;
`endif
        OP_HLT:   next_pc = pc;
        default:  next_pc = pc_inc;
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer of the single-cycle YouseiOS core.
// Picks the next fetch address each cycle, stalls the core while an IN/OUT
// handshake is pending and parks in HALTED after HLT until reset.
// Ports:
//   clock : core clock, all state changes on the rising edge
//   reset : synchronous, active-low reset
//   bus   : pc_sequencer_if.slave (instruction fields, IO handshake,
//           pc/in_ack/out_valid/stall/halted)
// Parameters: ADDR_W (PC width), RESET_PC (reset PC),
//             KERNEL_BASE (kernel entry, only with KERNEL_SWAP_EN).
// Optional feature macro: KERNEL_SWAP_EN adds the kret register; SWAPK saves
// pc+1 and jumps to KERNEL_BASE, JR with jr_tgt==0 returns to kret.
// in_ack, out_valid and stall are combinational so that a zero-wait IN/OUT
// retires in the same cycle; halted is decoded straight from the state register.
module pc_sequencer
  import yousei_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef KERNEL_SWAP_EN
  ,
  parameter logic [ADDR_W-1:0] KERNEL_BASE = '0
`endif
) (
  input logic           clock,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc, next_pc;
  logic              in_ack, out_valid, stall;
`ifdef KERNEL_SWAP_EN
  logic [ADDR_W-1:0] kret_q, kret_d;
`endif

  pc_next_mux #(
    .ADDR_W      (ADDR_W)
`ifdef KERNEL_SWAP_EN
    ,
    .KERNEL_BASE (KERNEL_BASE)
`endif
  ) u_next_mux (
    .opcode     (bus.opcode),
    .zero       (bus.zero),
    .pc         (pc_q),
    .alu_result (bus.alu_result),
    .branch_tgt (bus.branch_tgt),
    .jr_tgt     (bus.jr_tgt),
`ifdef KERNEL_SWAP_EN
    .kret       (kret_q),
`endif
    .pc_inc     (pc_inc),
    .next_pc    (next_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    in_ack    = 1'b0;
    out_valid = 1'b0;
    stall     = 1'b0;
`ifdef KERNEL_SWAP_EN
    kret_d    = kret_q;
`endif
    unique case (state_q)
      RUN: begin
        case (bus.opcode)
          // in_ack is only ever raised for IN, so a stray in_valid under any
          // other opcode is ignored.
          OP_IN: begin
            in_ack = bus.in_valid;
            if (bus.in_valid) begin
              pc_d = pc_inc;
            end else begin
              stall   = 1'b1;
              state_d = WAIT_IN;
            end
          end
          OP_OUT: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
              pc_d = pc_inc;
            end else begin
              stall   = 1'b1;
              state_d = WAIT_OUT;
            end
          end
          OP_HLT: begin
            state_d = HALTED;
          end
`ifdef KERNEL_SWAP_EN
          OP_SWAPK: begin
            kret_d = pc_inc;
            pc_d   = next_pc;
          end
`endif
          default: pc_d = next_pc;
        endcase
      end
      // The instruction is still the one at pc, so retiring is simply pc+1.
      WAIT_IN: begin
        in_ack = bus.in_valid;
        stall  = !bus.in_valid;
        if (bus.in_valid) begin
          pc_d    = pc_inc;
          state_d = RUN;
        end
      end
      WAIT_OUT: begin
        out_valid = 1'b1;
        stall     = !bus.out_ready;
        if (bus.out_ready) begin
          pc_d    = pc_inc;
          state_d = RUN;
        end
      end
      HALTED: begin
        stall = 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    // Reset is sampled at the edge and overrides everything, including a
    // half-finished IN/OUT handshake.
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
`ifdef KERNEL_SWAP_EN
      kret_q  <= RESET_PC;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef KERNEL_SWAP_EN
      kret_q  <= kret_d;
`endif
    end
  end

  assign bus.pc        = pc_q;
  assign bus.in_ack    = in_ack;
  assign bus.out_valid = out_valid;
  assign bus.stall     = stall;
  assign bus.halted    = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// A 32-bit instance runs a directed vector table and then randomized traffic
// against a cycle-level reference model; a 4-bit instance covers PC
// wrap-around and, when KERNEL_SWAP_EN is defined, the kernel swap/return.
module tb_pc_sequencer;
  import yousei_pkg::*;

  localparam logic [31:0] KB32 = 32'h0000_0100;
  localparam logic [3:0]  KB4  = 4'd8;

  logic clock = 1'b0;
  logic rst_n;
  logic rst4_n;
  always #5 clock = ~clock;

  pc_sequencer_if #(.ADDR_W(32)) bus ();
  pc_sequencer_if #(.ADDR_W(4))  bus4 ();

`ifdef KERNEL_SWAP_EN
  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'd0), .KERNEL_BASE(KB32))
    dut (.clock(clock), .reset(rst_n), .bus(bus));
  pc_sequencer #(.ADDR_W(4), .RESET_PC(4'd0), .KERNEL_BASE(KB4))
    dut4 (.clock(clock), .reset(rst4_n), .bus(bus4));
`else
  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'd0))
    dut (.clock(clock), .reset(rst_n), .bus(bus));
  pc_sequencer #(.ADDR_W(4), .RESET_PC(4'd0))
    dut4 (.clock(clock), .reset(rst4_n), .bus(bus4));
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst_n;
    logic [5:0]  op;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] btgt;
    logic [31:0] jtgt;
    logic        in_v;
    logic        out_r;
    logic [31:0] e_pc;
    logic        e_ack;
    logic        e_ov;
    logic        e_st;
    logic        e_h;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [5:0] op, input logic z,
                              input logic [31:0] alu, input logic [31:0] bt,
                              input logic [31:0] jt, input logic iv, input logic orr,
                              input logic [31:0] epc, input logic ea, input logic eov,
                              input logic es, input logic eh);
    vec_t v;
    v.rst_n = r;   v.op = op;     v.zero = z;   v.alu = alu;  v.btgt = bt;
    v.jtgt = jt;   v.in_v = iv;   v.out_r = orr;
    v.e_pc = epc;  v.e_ack = ea;  v.e_ov = eov; v.e_st = es;  v.e_h = eh;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic [5:0] op, input logic z,
                       input logic [31:0] alu, input logic [31:0] bt,
                       input logic [31:0] jt, input logic iv, input logic orr);
    rst_n          = r;
    bus.opcode     = op;
    bus.zero       = z;
    bus.alu_result = alu;
    bus.branch_tgt = bt;
    bus.jr_tgt     = jt;
    bus.in_valid   = iv;
    bus.out_ready  = orr;
  endtask

  task automatic drive4(input logic r, input logic [5:0] op, input logic [3:0] alu,
                        input logic [3:0] jt);
    rst4_n          = r;
    bus4.opcode     = op;
    bus4.zero       = 1'b0;
    bus4.alu_result = alu;
    bus4.branch_tgt = 4'd0;
    bus4.jr_tgt     = jt;
    bus4.in_valid   = 1'b0;
    bus4.out_ready  = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] epc, input logic ea,
                               input logic eov, input logic es, input logic eh);
    check({tag, ".pc"},        bus.pc,               epc);
    check({tag, ".in_ack"},    32'(bus.in_ack),      32'(ea));
    check({tag, ".out_valid"}, 32'(bus.out_valid),   32'(eov));
    check({tag, ".stall"},     32'(bus.stall),       32'(es));
    check({tag, ".halted"},    32'(bus.halted),      32'(eh));
  endtask

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference model: the architectural view of the sequencer.
  logic [31:0] m_pc, m_kret;
  bit          m_halted, m_wait_in, m_wait_out;

  function automatic logic [5:0] pick_op();
    int r;
    r = $urandom_range(0, 19);
    case (r)
      0, 1:    return OP_ADD;
      2:       return OP_LOG;
      3, 4:    return OP_JUMP;
      5, 6:    return OP_IN;
      7, 8:    return OP_OUT;
      9, 10:   return OP_BEQ;
      11, 12:  return OP_BNE;
      13, 14:  return OP_JR;
      15, 16:  return OP_SWAPK;
      17:      return OP_HLT;
      18:      return 6'd2;
      default: return 6'd40;
    endcase
  endfunction

  initial begin
    logic [5:0]  s_op;
    logic        s_rst, s_z, s_iv, s_or;
    logic [31:0] s_alu, s_bt, s_jt;
    logic        e_ack, e_ov, e_st, e_h;
    logic [31:0] n_pc, n_kret;
    bit          n_hl, n_wi, n_wo;

    drive(1'b0, OP_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive4(1'b0, OP_ADD, 4'd0, 4'd0);
    next_cycle();

    // ---------------- directed vector table ----------------
    //   r  op        z  alu            bt      jt     iv orr  pc             ack ov st h
    add(0, OP_ADD,   0, 0,             0,      0,     0, 0,  0,             0, 0, 0, 0);
    add(1, OP_ADD,   0, 0,             0,      0,     0, 0,  0,             0, 0, 0, 0);
    add(1, OP_ADD,   0, 0,             0,      0,     0, 0,  1,             0, 0, 0, 0);
    add(1, OP_ADD,   0, 0,             0,      0,     0, 0,  2,             0, 0, 0, 0);
    add(1, OP_ADD,   0, 0,             0,      0,     0, 0,  3,             0, 0, 0, 0);
    add(1, OP_BEQ,   1, 0,             20,     0,     0, 0,  4,             0, 0, 0, 0);
    add(1, OP_JUMP,  1, 4,             0,      0,     0, 0,  20,            0, 0, 0, 0);
    add(1, OP_BEQ,   0, 0,             20,     0,     0, 0,  4,             0, 0, 0, 0);
    add(1, OP_BNE,   1, 0,             7,      0,     1, 0,  5,             0, 0, 0, 0);
    add(1, OP_IN,    0, 0,             0,      0,     0, 0,  7,             0, 0, 1, 0);
    add(1, OP_IN,    0, 0,             0,      0,     0, 0,  7,             0, 0, 1, 0);
    add(1, OP_IN,    0, 0,             0,      0,     0, 0,  7,             0, 0, 1, 0);
    add(1, OP_IN,    0, 0,             0,      0,     1, 0,  7,             1, 0, 0, 0);
    add(1, OP_JR,    0, 0,             0,      9,     0, 0,  8,             0, 0, 0, 0);
    add(1, OP_OUT,   0, 0,             0,      0,     0, 0,  9,             0, 1, 1, 0);
    add(1, OP_OUT,   0, 0,             0,      0,     0, 0,  9,             0, 1, 1, 0);
    add(1, OP_OUT,   0, 0,             0,      0,     0, 1,  9,             0, 1, 0, 0);
    add(1, OP_IN,    0, 0,             0,      0,     1, 0,  10,            1, 0, 0, 0);
    add(1, OP_OUT,   0, 0,             0,      0,     0, 1,  11,            0, 1, 0, 0);
    add(1, OP_HLT,   0, 0,             0,      0,     0, 0,  12,            0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      if (k % 3 == 0)      add(1, OP_JUMP, 1, 99, 0, 0, 0, 0, 12, 0, 0, 1, 1);
      else if (k % 3 == 1) add(1, OP_IN,   0, 0,  0, 0, 1, 0, 12, 0, 0, 1, 1);
      else                 add(1, OP_ADD,  0, 0,  0, 0, 0, 1, 12, 0, 0, 1, 1);
    end
    add(0, OP_HLT,   0, 0,             0,      0,     0, 0,  12,            0, 0, 1, 1);
    add(1, OP_ADD,   0, 0,             0,      0,     0, 0,  0,             0, 0, 0, 0);
    add(1, OP_IN,    0, 0,             0,      0,     0, 0,  1,             0, 0, 1, 0);
    add(1, OP_IN,    0, 0,             0,      0,     0, 0,  1,             0, 0, 1, 0);
    add(0, OP_IN,    0, 0,             0,      0,     1, 0,  1,             1, 0, 0, 0);
    add(1, OP_ADD,   0, 0,             0,      0,     0, 0,  0,             0, 0, 0, 0);
    add(1, OP_OUT,   0, 0,             0,      0,     0, 0,  1,             0, 1, 1, 0);
    add(0, OP_OUT,   0, 0,             0,      0,     0, 0,  1,             0, 1, 1, 0);
    add(1, OP_ADD,   0, 0,             0,      0,     0, 0,  0,             0, 0, 0, 0);
    add(1, OP_JUMP,  1, 32'hFFFF_FFFF, 0,      0,     0, 0,  1,             0, 0, 0, 0);
    add(1, OP_ADD,   0, 0,             0,      0,     0, 0,  32'hFFFF_FFFF, 0, 0, 0, 0);
    add(1, OP_BNE,   0, 0,             50,     0,     0, 0,  0,             0, 0, 0, 0);
    add(1, OP_ADD,   0, 0,             0,      0,     0, 0,  1,             0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].op, vecs[i].zero, vecs[i].alu, vecs[i].btgt,
            vecs[i].jtgt, vecs[i].in_v, vecs[i].out_r);
      #1;
      check_outputs($sformatf("row%0d", i), vecs[i].e_pc, vecs[i].e_ack,
                    vecs[i].e_ov, vecs[i].e_st, vecs[i].e_h);
      next_cycle();
    end

    // ---------------- randomized run against the model ----------------
    drive(1'b0, OP_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    next_cycle();
    m_pc = 32'd0; m_kret = 32'd0;
    m_halted = 1'b0; m_wait_in = 1'b0; m_wait_out = 1'b0;
    s_op = OP_ADD;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!(m_wait_in || m_wait_out)) s_op = pick_op();
      s_rst = m_halted ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) != 0);
      s_z   = 1'($urandom_range(0, 1));
      s_iv  = ($urandom_range(0, 2) == 0);
      s_or  = ($urandom_range(0, 2) == 0);
      s_alu = $urandom();
      s_bt  = $urandom();
      s_jt  = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom();
      drive(s_rst, s_op, s_z, s_alu, s_bt, s_jt, s_iv, s_or);

      e_ack = 1'b0; e_ov = 1'b0; e_st = 1'b0; e_h = 1'b0;
      n_pc = m_pc; n_kret = m_kret; n_hl = m_halted; n_wi = 1'b0; n_wo = 1'b0;
      if (m_halted) begin
        e_st = 1'b1;
        e_h  = 1'b1;
      end else if (m_wait_in || s_op == OP_IN) begin
        e_ack = s_iv;
        e_st  = !s_iv;
        if (s_iv) n_pc = m_pc + 32'd1;
        else      n_wi = 1'b1;
      end else if (m_wait_out || s_op == OP_OUT) begin
        e_ov = 1'b1;
        e_st = !s_or;
        if (s_or) n_pc = m_pc + 32'd1;
        else      n_wo = 1'b1;
      end else begin
        case (s_op)
          OP_JUMP:        n_pc = s_alu;
          OP_BEQ, OP_BNE: n_pc = s_z ? s_bt : m_pc + 32'd1;
`ifdef KERNEL_SWAP_EN
          OP_JR:          n_pc = (s_jt == 32'd0) ? m_kret : s_jt;
          OP_SWAPK: begin
            n_kret = m_pc + 32'd1;
            n_pc   = KB32;
          end
`else
          OP_JR:          n_pc = s_jt;
`endif
          OP_HLT:         n_hl = 1'b1;
          default:        n_pc = m_pc + 32'd1;
        endcase
      end
      if (!s_rst) begin
        n_pc = 32'd0; n_kret = 32'd0; n_hl = 1'b0; n_wi = 1'b0; n_wo = 1'b0;
      end

      #1;
      check_outputs($sformatf("rnd%0d", cyc), m_pc, e_ack, e_ov, e_st, e_h);
      m_pc = n_pc; m_kret = n_kret; m_halted = n_hl;
      m_wait_in = n_wi; m_wait_out = n_wo;
      next_cycle();
    end

    // ---------------- 4-bit instance: wrap and kernel swap ----------------
    drive(1'b0, OP_ADD, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive4(1'b0, OP_ADD, 4'd0, 4'd0);
    next_cycle();
    drive4(1'b1, OP_JUMP, 4'd15, 4'd0);
    #1; check("w4.reset_pc", 32'(bus4.pc), 32'd0);
    next_cycle();
    drive4(1'b1, OP_ADD, 4'd0, 4'd0);
    #1; check("w4.pc15", 32'(bus4.pc), 32'd15);
    next_cycle();
    drive4(1'b1, OP_JUMP, 4'd3, 4'd0);
    #1; check("w4.wrap", 32'(bus4.pc), 32'd0);
    next_cycle();
    drive4(1'b1, OP_SWAPK, 4'd0, 4'd0);
    #1; check("w4.pc3", 32'(bus4.pc), 32'd3);
    next_cycle();
    drive4(1'b1, OP_JR, 4'd0, 4'd0);
`ifdef KERNEL_SWAP_EN
    #1; check("w4.swapk", 32'(bus4.pc), 32'(KB4));
`else
    #1; check("w4.swapk", 32'(bus4.pc), 32'd4);
`endif
    next_cycle();
    drive4(1'b1, OP_ADD, 4'd0, 4'd0);
`ifdef KERNEL_SWAP_EN
    #1; check("w4.jr_ret", 32'(bus4.pc), 32'd4);
`else
    #1; check("w4.jr_ret", 32'(bus4.pc), 32'd0);
`endif
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
